dpram_be: RTL and testbench
===========================

Name: dpram_be

Overview:
- Single-clock true dual-port RAM with per-byte write enables, selectable read latency and read-during-write policy.
- Adds cross-port write-collision detection and an optional sequential clear engine that zeroes the whole array on request.
- General-purpose storage for video/character buffers and CPU-shared RAM. Both ports are symmetric apart from collision priority.

Parameters:
- address_width, 10, address bits per port; depth = 2**address_width words.
- data_width, 16, word width; must be a multiple of 8. byte_count = data_width/8.
- read_latency, 1, clocks from address to q. Legal values are 1 and 2; any other value is an elaboration error.
- rdw_mode, 0, same-port read-during-write result: 0 = new (merged) word, 1 = old word.
- init_file, "", hex file loaded into the array at time zero when non-empty.

Ports:
- clock  in  1  single clock, all logic on rising edge
- reset_n  in  1  synchronous, active-low reset
- wren_a  in  1  port A write request
- byteena_a  in  byte_count  port A byte enables; bit i covers data_a[8i+7:8i]
- address_a  in  address_width  port A address
- data_a  in  data_width  port A write data
- q_a  out  data_width  port A read data
- wren_b, byteena_b, address_b, data_b, q_b: as port A, for port B
- collision  out  1  one-cycle pulse: both ports wrote overlapping bytes of one address
- clear_req  in  1  start whole-array clear (DPRAM_CLEAR_EN only)
- busy  out  1  clear in progress

Behaviour:
- Interface decision: one clock; reset is synchronous and active-low (clock, reset_n).
- Reset (reset_n=0 at a rising edge):
  - q_a, q_b, all pipeline registers, collision and busy go to 0.
  - Clear FSM returns to IDLE.
  - Array contents are not modified.
- Write:
  - Occurs when wren_x=1. Only bytes with byteena_x[i]=1 are updated.
  - wren_x=1 with byteena_x=0 writes nothing, but the read still proceeds.
- Read:
  - read_latency=1: q_x is registered and valid on the edge after the address is sampled.
  - read_latency=2: one extra output register stage; q_x appears one cycle later.
  - q_x updates every cycle; there is no read enable.
- Same-port read-during-write:
  - rdw_mode=0: q_x = stored word with the enabled bytes replaced by data_x.
  - rdw_mode=1: q_x = stored word before the write.
- Cross-port, same address, same cycle:
  - One port writes, the other reads: the reader gets the old word, independent of rdw_mode.
  - Both ports write: port A wins on bytes enabled by both. Bytes enabled only by B take data_b.
  - collision=1 on the next cycle iff wren_a & wren_b & (address_a==address_b) & |(byteena_a & byteena_b). Otherwise collision=0.
  - collision is not delayed by read_latency.
- Clear FSM, states IDLE and CLEAR:
  - IDLE -> CLEAR when clear_req=1 and reset_n=1. The counter loads 0 and busy=1 from the next cycle.
  - In CLEAR, one word per cycle at counter address is written with all zeros; the counter increments.
  - After address 2**address_width-1 is written: CLEAR -> IDLE, and busy=0 on the following cycle.
  - busy stays high for exactly 2**address_width cycles.
  - While busy=1:
    - user writes on both ports are dropped; collision stays 0.
    - q_a is forced to 0.
    - port B reads continue and may return cleared or not-yet-cleared words.
  - clear_req while busy is ignored. clear_req held high after completion restarts the clear.
  - Reset mid-clear aborts: busy=0 next cycle. Addresses already cleared remain 0; the rest are unchanged.

Optional Feature:
- Macro: DPRAM_CLEAR_EN.
- Defined: clear FSM, counter and busy logic are present as described above.
- Undefined:
  - busy is tied to 0 and clear_req is ignored; no counter logic is synthesised.
  - User writes are never blocked and q_a is never forced.

Test Plan:
- Setup: data_width=16, address_width=4, read_latency=1, rdw_mode=0. Write 0xBEEF @3 on port A, byteena=2'b11. Read @3 on port B -> q_b=0xBEEF one cycle after the address.
- Byte enables: port A writes 0x12xx @3 with byteena=2'b10 -> q_b reads 0x12EF. With rdw_mode=1, the same write gives q_a=0xBEEF in that cycle and q_a=0x12EF on the next read.
- Dual write: same cycle, A writes 0xAAAA with byteena=2'b01, B writes 0x5555 with byteena=2'b11, both @7. Result: collision=1 for one cycle; word @7 = 0x55AA.
- read_latency=2: address @3 presented at cycle N -> q_b=0x12EF at edge N+2; q_b is not yet updated at edge N+1.
- Clear (DPRAM_CLEAR_EN): pulse clear_req.
  - busy is high for exactly 16 cycles; a port A write attempted mid-clear is lost.
  - After busy falls, all 16 words read 0x0000.
- Reset mid-clear: assert reset_n=0 after 5 clear cycles.
  - busy=0 next cycle.
  - Words 0–4 read 0; word 7 still reads 0x55AA.

Source files
------------

// File: rtl/dpram_be.sv
// Single-clock true dual-port RAM with per-byte enables, 1- or 2-cycle read latency and a
// cross-port write-collision flag. Define DPRAM_CLEAR_EN to build the sequential clear engine.
module dpram_be #(
    parameter int    address_width = 10,
    parameter int    data_width    = 16,
    parameter int    read_latency  = 1,
    parameter int    rdw_mode      = 0,
    parameter string init_file     = ""
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        wren_a,
    input  logic [data_width/8-1:0]     byteena_a,
    input  logic [address_width-1:0]    address_a,
    input  logic [data_width-1:0]       data_a,
    output logic [data_width-1:0]       q_a,
    input  logic                        wren_b,
    input  logic [data_width/8-1:0]     byteena_b,
    input  logic [address_width-1:0]    address_b,
    input  logic [data_width-1:0]       data_b,
    output logic [data_width-1:0]       q_b,
    output logic                        collision,
    input  logic                        clear_req,
    output logic                        busy
);

    localparam int                       byte_count = data_width / 8;
    localparam int                       depth      = 2 ** address_width;
    localparam bit                       rdw_new    = (rdw_mode == 0);
    localparam logic [data_width-1:0]    zero_word  = {data_width{1'b0}};

    if ((read_latency != 1) && (read_latency != 2)) begin : g_bad_latency
        $error("dpram_be: read_latency must be 1 or 2");
    end
    if (((data_width % 8) != 0) || (data_width < 8)) begin : g_bad_width
        $error("dpram_be: data_width must be a non-zero multiple of 8");
    end
    if ((rdw_mode != 0) && (rdw_mode != 1)) begin : g_bad_rdw
        $error("dpram_be: rdw_mode must be 0 or 1");
    end

    function automatic logic [data_width-1:0] merge_bytes(
        input logic [data_width-1:0] old_w,
        input logic [data_width-1:0] new_w,
        input logic [byte_count-1:0] be
    );
        logic [data_width-1:0] res;
        res = old_w;
        for (int i = 0; i < byte_count; i++) begin
            res[8*i +: 8] = be[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
        end
        return res;
    endfunction

    logic [data_width-1:0]    mem_q [depth];
    logic [data_width-1:0]    rd_a_s, rd_b_s;
    logic [data_width-1:0]    rd_a_q, rd_b_q, out_a_q, out_b_q;
    logic                     collision_q;
    logic                     we_a_s, we_b_s, coll_s;
    logic                     busy_q, busy_d;
    logic                     clr_we_s;
    logic [address_width-1:0] clr_addr_s;

`ifdef DPRAM_CLEAR_EN
    typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} clr_state_e;

    localparam logic [address_width-1:0] last_addr = {address_width{1'b1}};

    clr_state_e               state_q;
    logic [address_width-1:0] clr_cnt_q;

    // busy_d is the busy value for the coming cycle; it also gates the port A read data
    always_comb begin
        busy_d = 1'b0;
        if (!reset_n) begin
            busy_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE:  busy_d = clear_req;
                ST_CLEAR: busy_d = (clr_cnt_q != last_addr);
                default:  busy_d = 1'b0;
            endcase
        end
    end

    // clear sequencer: one word per cycle from address 0 up to the last address
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            clr_cnt_q <= {address_width{1'b0}};
            busy_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (clear_req) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= {address_width{1'b0}};
                    end
                end
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + address_width'(1'b1);
                    if (clr_cnt_q == last_addr) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            busy_q <= busy_d;
        end
    end

    // a reset arriving mid-clear must not zero the word at the current count
    assign clr_we_s   = reset_n && (state_q == ST_CLEAR);
    assign clr_addr_s = clr_cnt_q;
`else
    logic unused_clear_s;

    assign unused_clear_s = clear_req;
    assign busy_d         = 1'b0;
    assign busy_q         = 1'b0;
    assign clr_we_s       = 1'b0;
    assign clr_addr_s     = {address_width{1'b0}};
`endif

    assign we_a_s = wren_a && !busy_q;
    assign we_b_s = wren_b && !busy_q;
    assign coll_s = we_a_s && we_b_s && (address_a == address_b) &&
                    ((byteena_a & byteena_b) != {byte_count{1'b0}});

    // array update: B bytes first, then A bytes, so A owns bytes both ports enable
    always_ff @(posedge clock) begin
        if (clr_we_s) begin
            mem_q[clr_addr_s] <= zero_word;
        end else begin
            for (int i = 0; i < byte_count; i++) begin
                if (we_b_s && byteena_b[i]) begin
                    mem_q[address_b][8*i +: 8] <= data_b[8*i +: 8];
                end
                if (we_a_s && byteena_a[i]) begin
                    mem_q[address_a][8*i +: 8] <= data_a[8*i +: 8];
                end
            end
        end
    end

    // read data: a port sees its own write only in new-data mode, never the other port's
    always_comb begin
        rd_a_s = mem_q[address_a];
        rd_b_s = mem_q[address_b];
        if (rdw_new && we_a_s) begin
            rd_a_s = merge_bytes(mem_q[address_a], data_a, byteena_a);
        end else begin
            rd_a_s = mem_q[address_a];
        end
        if (rdw_new && we_b_s) begin
            rd_b_s = merge_bytes(mem_q[address_b], data_b, byteena_b);
        end else begin
            rd_b_s = mem_q[address_b];
        end
    end

    // output pipeline and collision flag
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_a_q      <= zero_word;
            rd_b_q      <= zero_word;
            out_a_q     <= zero_word;
            out_b_q     <= zero_word;
            collision_q <= 1'b0;
        end else begin
            rd_a_q      <= busy_d ? zero_word : rd_a_s;
            rd_b_q      <= rd_b_s;
            out_a_q     <= busy_d ? zero_word : rd_a_q;
            out_b_q     <= rd_b_q;
            collision_q <= coll_s;
        end
    end

    assign q_a       = (read_latency == 2) ? out_a_q : rd_a_q;
    assign q_b       = (read_latency == 2) ? out_b_q : rd_b_q;
    assign collision = collision_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dpram_be.sv
// Bench for dpram_be: two instances (latency 1/new-data and latency 2/old-data) share one
// stimulus stream and are compared every cycle against a word-array reference model.
`timescale 1ns/1ps
module tb_dpram_be;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int BC    = 2;
    localparam int DEPTH = 16;
`ifdef DPRAM_CLEAR_EN
    localparam bit CLR_EN = 1'b1;
`else
    localparam bit CLR_EN = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          wren_a = 1'b0, wren_b = 1'b0, clear_req = 1'b0;
    logic [BC-1:0] byteena_a = '0, byteena_b = '0;
    logic [AW-1:0] address_a = '0, address_b = '0;
    logic [DW-1:0] data_a = '0, data_b = '0;
    logic [DW-1:0] q_a0, q_b0, q_a1, q_b1;
    logic          coll0, coll1, busy0, busy1;

    always #5 clock = ~clock;

    dpram_be #(.address_width(AW), .data_width(DW), .read_latency(1), .rdw_mode(0)) u0 (
        .clock(clock), .reset_n(reset_n),
        .wren_a(wren_a), .byteena_a(byteena_a), .address_a(address_a), .data_a(data_a), .q_a(q_a0),
        .wren_b(wren_b), .byteena_b(byteena_b), .address_b(address_b), .data_b(data_b), .q_b(q_b0),
        .collision(coll0), .clear_req(clear_req), .busy(busy0)
    );

    dpram_be #(.address_width(AW), .data_width(DW), .read_latency(2), .rdw_mode(1)) u1 (
        .clock(clock), .reset_n(reset_n),
        .wren_a(wren_a), .byteena_a(byteena_a), .address_a(address_a), .data_a(data_a), .q_a(q_a1),
        .wren_b(wren_b), .byteena_b(byteena_b), .address_b(address_b), .data_b(data_b), .q_b(q_b1),
        .collision(coll1), .clear_req(clear_req), .busy(busy1)
    );

    int n_chk = 0;
    int n_pass = 0;

    // one read sample: word, bytes whose value the model knows, taken while clearing
    typedef struct packed {
        bit [DW-1:0] w;
        bit [BC-1:0] m;
        bit          bz;
    } samp_t;

    localparam samp_t RST_S = '{w: 16'h0000, m: 2'b11, bz: 1'b0};

    bit [DW-1:0] mem   [DEPTH];
    bit [BC-1:0] known [DEPTH];
    bit          m_busy = 1'b0;
    bit          m_coll = 1'b0;
    int          m_cnt  = 0;
    samp_t       a0 = '0, b0 = '0, a1p = '0, b1p = '0, a1 = '0, b1 = '0;

    function automatic bit [DW-1:0] merge(bit [DW-1:0] old_w, bit [DW-1:0] new_w, bit [BC-1:0] be);
        bit [DW-1:0] r;
        r = old_w;
        for (int i = 0; i < BC; i++) if (be[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    task automatic check(string name, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic check_q(string name, logic [DW-1:0] act, samp_t s, bit port_a);
        logic [DW-1:0] mk;
        for (int i = 0; i < BC; i++) mk[8*i +: 8] = {8{s.m[i]}};
        if (port_a && m_busy) check(name, act, 16'h0000);
        else if (!(port_a && s.bz) && (s.m != 2'b00)) check(name, act & mk, s.w & mk);
    endtask

    task automatic model_step();
        bit [DW-1:0] oa, ob, na, nb;
        bit [BC-1:0] ka, kb;
        bit          bz, ewa, ewb;
        if (!reset_n) begin
            m_busy = 1'b0; m_coll = 1'b0;
            a0 = RST_S; b0 = RST_S; a1p = RST_S; b1p = RST_S; a1 = RST_S; b1 = RST_S;
        end else begin
            bz  = m_busy;
            ewa = wren_a && !bz;
            ewb = wren_b && !bz;
            oa = mem[address_a]; ka = known[address_a];
            ob = mem[address_b]; kb = known[address_b];
            na = ewa ? merge(oa, data_a, byteena_a) : oa;
            nb = ewb ? merge(ob, data_b, byteena_b) : ob;
            a0 = '{w: na, m: ewa ? (ka | byteena_a) : ka, bz: bz};
            b0 = '{w: nb, m: ewb ? (kb | byteena_b) : kb, bz: bz};
            a1 = a1p; b1 = b1p;
            a1p = '{w: oa, m: ka, bz: bz};
            b1p = '{w: ob, m: kb, bz: bz};
            m_coll = ewa && ewb && (address_a == address_b) && ((byteena_a & byteena_b) != 2'b00);
            if (bz) begin
                mem[m_cnt] = 16'h0000; known[m_cnt] = 2'b11;
                if (m_cnt == DEPTH - 1) m_busy = 1'b0;
                m_cnt++;
            end else begin
                if (ewb) begin
                    mem[address_b] = merge(mem[address_b], data_b, byteena_b);
                    known[address_b] |= byteena_b;
                end
                if (ewa) begin
                    mem[address_a] = merge(mem[address_a], data_a, byteena_a);
                    known[address_a] |= byteena_a;
                end
                if (CLR_EN && clear_req) begin
                    m_busy = 1'b1; m_cnt = 0;
                end
            end
        end
    endtask

    // model advances on each edge; outputs are compared 1 ns later
    always @(posedge clock) begin
        model_step();
        #1;
        check("busy_u0", 16'(busy0), 16'(m_busy));
        check("busy_u1", 16'(busy1), 16'(m_busy));
        check("collision_u0", 16'(coll0), 16'(m_coll));
        check("collision_u1", 16'(coll1), 16'(m_coll));
        check_q("q_a_u0", q_a0, a0, 1'b1);
        check_q("q_b_u0", q_b0, b0, 1'b0);
        check_q("q_a_u1", q_a1, a1, 1'b1);
        check_q("q_b_u1", q_b1, b1, 1'b0);
    end

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic set_a(bit we, bit [BC-1:0] be, bit [AW-1:0] ad, bit [DW-1:0] d);
        wren_a = we; byteena_a = be; address_a = ad; data_a = d;
    endtask

    task automatic set_b(bit we, bit [BC-1:0] be, bit [AW-1:0] ad, bit [DW-1:0] d);
        wren_b = we; byteena_b = be; address_b = ad; data_b = d;
    endtask

    int n;

    initial begin
        repeat (3) tick();
        check("rst_q_a0", q_a0, 16'h0000);
        check("rst_q_b1", q_b1, 16'h0000);
        check("rst_collision", 16'(coll0), 16'h0000);
        check("rst_busy", 16'(busy0), 16'h0000);
        reset_n = 1'b1;

        set_a(1'b1, 2'b11, 4'd3, 16'hBEEF); set_b(1'b0, 2'b00, 4'd0, 16'h0000); tick();
        set_a(1'b0, 2'b11, 4'd3, 16'h0000); set_b(1'b0, 2'b00, 4'd3, 16'h0000); tick();
        check("write_read_b", q_b0, 16'hBEEF);
        set_a(1'b1, 2'b10, 4'd3, 16'h1234); tick();
        check("byte_merge_new", q_a0, 16'h12EF);
        check("xport_read_old", q_b0, 16'hBEEF);
        set_a(1'b0, 2'b00, 4'd3, 16'h0000); tick();
        check("byte_read_b", q_b0, 16'h12EF);
        check("rdw_old_a", q_a1, 16'hBEEF);
        check("lat2_not_yet", q_b1, 16'hBEEF);
        tick();
        check("rdw_next_read", q_a1, 16'h12EF);
        check("lat2_read", q_b1, 16'h12EF);

        set_a(1'b1, 2'b01, 4'd7, 16'hAAAA); set_b(1'b1, 2'b11, 4'd7, 16'h5555); tick();
        check("collision_set", 16'(coll0), 16'h0001);
        set_a(1'b0, 2'b00, 4'd7, 16'h0000); set_b(1'b0, 2'b00, 4'd7, 16'h0000); tick();
        check("collision_pulse", 16'(coll0), 16'h0000);
        check("dual_write_word", q_b0, 16'h55AA);

        for (int k = 0; k < 800; k++) begin
            set_a(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 16'($urandom));
            set_b(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 7)), 16'($urandom));
            clear_req = ($urandom_range(0, 79) == 0);
            tick();
        end
        clear_req = 1'b0;
        set_a(1'b0, 2'b00, 4'd0, 16'h0000); set_b(1'b0, 2'b00, 4'd0, 16'h0000);
        for (int k = 0; k < 40 && busy0; k++) tick();
        check("busy_drained", 16'(busy0), 16'h0000);

`ifdef DPRAM_CLEAR_EN
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        check("busy_rise", 16'(busy0), 16'h0001);
        n = 0;
        while (busy0 && n < 40) begin
            n++;
            if (n == 8) set_a(1'b1, 2'b11, 4'd7, 16'h1234);
            else        set_a(1'b0, 2'b00, 4'd7, 16'h0000);
            tick();
        end
        check("busy_length", 16'(n), 16'd16);
        set_a(1'b0, 2'b00, 4'd0, 16'h0000);
        for (int i = 0; i < DEPTH; i++) begin
            set_b(1'b0, 2'b00, 4'(i), 16'h0000); tick();
            check("cleared_word", q_b0, 16'h0000);
        end
        for (int i = 0; i < 8; i++) begin
            set_a(1'b1, 2'b11, 4'(i), (i == 7) ? 16'h55AA : 16'(16'h0A00 + i)); tick();
        end
        set_a(1'b0, 2'b00, 4'd0, 16'h0000);
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        repeat (5) tick();
        reset_n = 1'b0; tick();
        check("busy_abort", 16'(busy0), 16'h0000);
        reset_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            set_b(1'b0, 2'b00, 4'(i), 16'h0000); tick();
            check("abort_word", q_b0, (i < 5) ? 16'h0000 : ((i == 7) ? 16'h55AA : 16'(16'h0A00 + i)));
        end
`else
        clear_req = 1'b1; tick(); clear_req = 1'b0;
        check("busy_tied_low", 16'(busy0), 16'h0000);
        set_a(1'b1, 2'b11, 4'd5, 16'hC0DE); tick();
        set_a(1'b0, 2'b00, 4'd5, 16'h0000); set_b(1'b0, 2'b00, 4'd5, 16'h0000); tick();
        check("write_not_blocked", q_b0, 16'hC0DE);
`endif
        tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
